pll_lock_supervisor: RTL



---
 rtl/pll_lock_supervisor.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences the PLL reset, qualifies the PLL lock with a stability window,
// retries lock timeouts a bounded number of times, and produces the system
// reset / ready / fail indications plus a saturating lock-loss counter.
// Runs on the free-running board clock that also feeds the PLL reference.

module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 7,
    parameter int CNT_W               = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fail,
    output logic [2:0]       retry_cnt,
    output logic [CNT_W-1:0] unlock_cnt
);

    // One timer serves all three windows, so it is sized for the longest one.
    localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Terminal timer values: the transition happens on the edge that sees them.
    localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]         RETRY_MAX   = 3'(MAX_RETRIES);
    localparam logic [CNT_W-1:0]   UNLOCK_SAT  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_nx_s;
    logic [2:0]         retry_nx_s;
    logic [CNT_W-1:0]   unlock_nx_s;
    logic               sync1_r;
    logic               lk_s;

    // Two-flop synchronizer: pll_locked is asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            sync1_r <= pll_locked;
            lk_s    <= sync1_r;
        end
    end

    // Next-state, timer and counter decisions from the current state and lk_s.
    always_comb begin
        state_nx_s  = state_r;
        timer_nx_s  = timer_r + TIMER_W'(1);
        retry_nx_s  = retry_cnt;
        unlock_nx_s = unlock_cnt;
        case (state_r)
            ST_PLL_RST: begin
                if (timer_r == RST_LAST) begin
                    state_nx_s = ST_WAIT_LOCK;
                    timer_nx_s = {TIMER_W{1'b0}};
                end else begin
                    state_nx_s = ST_PLL_RST;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (lk_s) begin
                    state_nx_s = ST_STABLE;
                    timer_nx_s = {TIMER_W{1'b0}};
                end else if (timer_r == TIMEOUT_LAST) begin
                    timer_nx_s = {TIMER_W{1'b0}};
                    if (retry_cnt == RETRY_MAX) begin
                        state_nx_s = ST_FAIL;
                    end else begin
                        state_nx_s = ST_PLL_RST;
                        retry_nx_s = retry_cnt + 3'd1;
                    end
                end else begin
                    state_nx_s = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                // A drop inside the window is a glitch, not a retry.
                if (!lk_s) begin
                    state_nx_s = ST_WAIT_LOCK;
                    timer_nx_s = {TIMER_W{1'b0}};
                end else if (timer_r == STABLE_LAST) begin
                    state_nx_s = ST_RUN;
                    timer_nx_s = {TIMER_W{1'b0}};
                    retry_nx_s = 3'd0;
                end else begin
                    state_nx_s = ST_STABLE;
                end
            end
            ST_RUN: begin
                timer_nx_s = timer_r;
                if (!lk_s) begin
                    state_nx_s = ST_PLL_RST;
                    timer_nx_s = {TIMER_W{1'b0}};
                    if (unlock_cnt != UNLOCK_SAT) begin
                        unlock_nx_s = unlock_cnt + CNT_W'(1);
                    end else begin
                        unlock_nx_s = unlock_cnt;
                    end
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FAIL: begin
                // Terminal until rst.
                state_nx_s = ST_FAIL;
                timer_nx_s = timer_r;
            end
            default: begin
                state_nx_s = ST_PLL_RST;
                timer_nx_s = {TIMER_W{1'b0}};
            end
        endcase
    end

    // State, counters and outputs; outputs are decoded from the next state so
    // they change on the same edge as the transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_PLL_RST;
            timer_r    <= {TIMER_W{1'b0}};
            retry_cnt  <= 3'd0;
            unlock_cnt <= {CNT_W{1'b0}};
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            timer_r    <= timer_nx_s;
            retry_cnt  <= retry_nx_s;
            unlock_cnt <= unlock_nx_s;
            pll_rst    <= (state_nx_s == ST_PLL_RST) || (state_nx_s == ST_FAIL);
            sys_rst    <= (state_nx_s != ST_RUN);
            ready      <= (state_nx_s == ST_RUN);
            fail       <= (state_nx_s == ST_FAIL);
        end
    end

endmodule
